// File: rtl/sa_cache_ctrl.sv
// Set-associative write-back / write-allocate data cache controller with tree pseudo-LRU.
// Serves one core request at a time and blocks on a miss until the refill completes.
module sa_cache_ctrl #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 128,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  input  logic [WORD_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [WORD_W-1:0]   rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [LINE_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [LINE_W-1:0]   mem_rsp_rdata
);
  localparam int OFF_W  = $clog2(LINE_W/8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BOFF_W = $clog2(WORD_W/8);
  localparam int WSEL_W = OFF_W - BOFF_W;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int PL_W   = NUM_WAYS - 1;
  localparam int STRB_W = WORD_W/8;
  localparam int WORDS  = LINE_W/WORD_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, WRITEBACK, REFILL_REQ, REFILL_WAIT} state_t;
  state_t state;

  logic [TAG_W-1:0]  tag_mem  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] data_mem [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [PL_W-1:0]     plru_q  [NUM_SETS];

  logic              r_we;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WSEL_W-1:0] r_wsel;
  logic [WORD_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [WAY_W-1:0]  v_way;

  logic              hit, refill, line_we;
  logic [WAY_W-1:0]  hit_way, vic_way, acc_way;
  logic [LINE_W-1:0] base_line, new_line;
  logic [WORD_W-1:0] new_word;
  logic              addr_unused;

  assign addr_unused = ^req_addr[BOFF_W-1:0];

  // Tree walk: node n has children 2n+1 (lower ways) and 2n+2; a bit of 0 sends the victim left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
    logic [WAY_W-1:0] way;
    logic [PL_W-1:0]  sh;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh = bits >> node;
      way[WAY_W-1-l] = sh[0];
      node = 2*node + 1 + int'(sh[0]);
    end
    return way;
  endfunction

  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [PL_W-1:0] res, mask;
    int node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      mask = PL_W'(1) << node;
      if (way[WAY_W-1-l]) res = res & ~mask;
      else                res = res | mask;
      node = 2*node + 1 + int'(way[WAY_W-1-l]);
    end
    return res;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[r_idx][w] && tag_mem[w][r_idx] == r_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    vic_way = plru_victim(plru_q[r_idx]);
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!valid_q[r_idx][w]) vic_way = WAY_W'(w);
    end
    refill    = (state == REFILL_WAIT) && mem_rsp_valid;
    acc_way   = refill ? v_way : hit_way;
    base_line = refill ? mem_rsp_rdata : data_mem[hit_way][r_idx];
    new_line  = base_line;
    new_word  = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_wsel == WSEL_W'(i)) begin
        new_word = base_line[i*WORD_W +: WORD_W];
        if (r_we) begin
          for (int b = 0; b < STRB_W; b++)
            if (r_wstrb[b]) new_word[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
        new_line[i*WORD_W +: WORD_W] = new_word;
      end
    end
    line_we = refill || (state == LOOKUP && hit && r_we);
  end

  // Line and tag storage carry no reset; writes only happen in LOOKUP/REFILL_WAIT.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[acc_way][r_idx] <= new_line;
    if (refill)  tag_mem[v_way][r_idx]    <= r_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      r_we          <= 1'b0;
      r_tag         <= '0;
      r_idx         <= '0;
      r_wsel        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      v_way         <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_we      <= req_we;
          r_tag     <= req_addr[ADDR_W-1 -: TAG_W];
          r_idx     <= req_addr[OFF_W +: IDX_W];
          r_wsel    <= req_addr[BOFF_W +: WSEL_W];
          r_wdata   <= req_wdata;
          r_wstrb   <= req_wstrb;
          req_ready <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          plru_q[r_idx] <= plru_touch(plru_q[r_idx], hit_way);
          if (r_we) dirty_q[r_idx][hit_way] <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= new_word;
          state     <= RESPOND;
        end else begin
          v_way         <= vic_way;
          mem_req_valid <= 1'b1;
          if (valid_q[r_idx][vic_way] && dirty_q[r_idx][vic_way]) begin
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {tag_mem[vic_way][r_idx], r_idx, {OFF_W{1'b0}}};
            mem_req_wdata <= data_mem[vic_way][r_idx];
            state         <= WRITEBACK;
          end else begin
            mem_req_we   <= 1'b0;
            mem_req_addr <= {r_tag, r_idx, {OFF_W{1'b0}}};
            state        <= REFILL_REQ;
          end
        end
        WRITEBACK: if (mem_req_ready) begin
          mem_req_we    <= 1'b0;
          mem_req_addr  <= {r_tag, r_idx, {OFF_W{1'b0}}};
          mem_req_wdata <= '0;
          state         <= REFILL_REQ;
        end
        REFILL_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= REFILL_WAIT;
        end
        REFILL_WAIT: if (mem_rsp_valid) begin
          valid_q[r_idx][v_way] <= 1'b1;
          dirty_q[r_idx][v_way] <= r_we;
          plru_q[r_idx]         <= plru_touch(plru_q[r_idx], v_way);
          rsp_valid <= 1'b1;
          rsp_rdata <= new_word;
          state     <= RESPOND;
        end
        RESPOND: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed bench for sa_cache_ctrl: an 8-way/128-set and a 2-way/16-set instance share stimulus;
// sel2 chooses which instance's outputs are observed.
module tb_sa_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_we = 1'b0;
  logic [31:0]  req_addr = '0, req_wdata = '0;
  logic [3:0]   req_wstrb = '0;
  logic         mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_rdata = '0;
  logic         sel2 = 1'b0;

  logic         req_ready_a, rsp_valid_a, mem_req_valid_a, mem_req_we_a;
  logic [31:0]  rsp_rdata_a, mem_req_addr_a;
  logic [127:0] mem_req_wdata_a;
  logic         req_ready_b, rsp_valid_b, mem_req_valid_b, mem_req_we_b;
  logic [31:0]  rsp_rdata_b, mem_req_addr_b;
  logic [127:0] mem_req_wdata_b;

  logic         req_ready, rsp_valid, mem_req_valid, mem_req_we;
  logic [31:0]  rsp_rdata, mem_req_addr;
  logic [127:0] mem_req_wdata;

  int n_chk = 0, n_pass = 0, n_mreq = 0;

  always #5 clk = ~clk;

  sa_cache_ctrl u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .mem_req_valid(mem_req_valid_a), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we_a), .mem_req_addr(mem_req_addr_a), .mem_req_wdata(mem_req_wdata_a),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata));

  sa_cache_ctrl #(.NUM_WAYS(2), .NUM_SETS(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we_b), .mem_req_addr(mem_req_addr_b), .mem_req_wdata(mem_req_wdata_b),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata));

  assign req_ready     = sel2 ? req_ready_b     : req_ready_a;
  assign rsp_valid     = sel2 ? rsp_valid_b     : rsp_valid_a;
  assign rsp_rdata     = sel2 ? rsp_rdata_b     : rsp_rdata_a;
  assign mem_req_valid = sel2 ? mem_req_valid_b : mem_req_valid_a;
  assign mem_req_we    = sel2 ? mem_req_we_b    : mem_req_we_a;
  assign mem_req_addr  = sel2 ? mem_req_addr_b  : mem_req_addr_a;
  assign mem_req_wdata = sel2 ? mem_req_wdata_b : mem_req_wdata_a;

  always @(negedge clk) if (mem_req_valid) n_mreq++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] addr_line(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req_ready"}, req_ready, 1'b1);
    chk({tag, " rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, " mem_req_we"}, mem_req_we, 1'b0);
    chk({tag, " mem_req_addr"}, mem_req_addr, 32'h0);
    chk({tag, " mem_req_wdata"}, mem_req_wdata, 128'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    chk("req_ready idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic hit_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] exp);
    int m0;
    issue(we, addr, wdata, wstrb);
    m0 = n_mreq;
    @(negedge clk);
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp);
    @(negedge clk);
    chk({tag, " rsp_pulse"}, rsp_valid, 1'b0);
    chk({tag, " no_mem"}, n_mreq, m0);
  endtask

  task automatic handshake();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  task automatic miss_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic wb, input logic [31:0] wb_addr,
                             input logic [127:0] wb_line, input logic [127:0] line,
                             input logic [31:0] exp, input int stall);
    int t;
    issue(we, addr, wdata, wstrb);
    t = 0;
    while (!mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " mreq"}, mem_req_valid, 1'b1);
    if (wb) begin
      for (int i = 0; i <= stall; i++) begin
        chk({tag, " wb_valid"}, mem_req_valid, 1'b1);
        chk({tag, " wb_we"}, mem_req_we, 1'b1);
        chk({tag, " wb_addr"}, mem_req_addr, wb_addr);
        chk({tag, " wb_data"}, mem_req_wdata, wb_line);
        chk({tag, " wb_req_ready"}, req_ready, 1'b0);
        if (i < stall) @(negedge clk);
      end
      handshake();
    end
    for (int i = 0; i <= stall; i++) begin
      chk({tag, " rf_valid"}, mem_req_valid, 1'b1);
      chk({tag, " rf_we"}, mem_req_we, 1'b0);
      chk({tag, " rf_addr"}, mem_req_addr, addr & 32'hFFFF_FFF0);
      chk({tag, " rf_req_ready"}, req_ready, 1'b0);
      if (i < stall) @(negedge clk);
    end
    handshake();
    chk({tag, " wait_idle_bus"}, mem_req_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = line;
    chk({tag, " rsp_early"}, rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp);
    @(negedge clk);
    chk({tag, " rsp_pulse"}, rsp_valid, 1'b0);
    chk({tag, " ready_back"}, req_ready, 1'b1);
  endtask

  localparam logic [127:0] L1     = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] L1_MOD = 128'h4444_4444_3333_CCDD_2222_2222_1111_1111;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    // 8-way: miss, hits, store merge
    do_reset();
    miss_access("ld1000", 0, 32'h1000, 0, 0, 0, 0, 0, L1, 32'h1111_1111, 0);
    hit_access("ld1004", 0, 32'h1004, 0, 0, 32'h2222_2222);
    hit_access("st1008", 1, 32'h1008, 32'hAABB_CCDD, 4'b0011, 32'h3333_CCDD);
    hit_access("ld1008", 0, 32'h1008, 0, 0, 32'h3333_CCDD);
    hit_access("st_nostrb", 1, 32'h100C, 32'hDEAD_BEEF, 4'b0000, 32'h4444_4444);
    // fill the rest of set 0, then evict the dirty 0x1000 line under memory backpressure
    for (int i = 0; i < 8; i++) begin
      if (i != 2)
        miss_access("fill", 0, 32'(i) * 32'h800, 0, 0, 0, 0, 0,
                    addr_line(32'(i) * 32'h800), 32'(i) * 32'h800, 0);
    end
    miss_access("evict_dirty", 0, 32'h4000, 0, 0, 1, 32'h1000, L1_MOD,
                addr_line(32'h4000), 32'h4000, 5);
    hit_access("ld0_after", 0, 32'h0, 0, 0, 32'h0);

    // 8-way PLRU: fill set 0, re-touch way 0, next miss must pick way 4 (0x2000)
    do_reset();
    for (int i = 0; i < 8; i++)
      miss_access("fill8", 0, 32'(i) * 32'h800, 0, 0, 0, 0, 0,
                  addr_line(32'(i) * 32'h800), 32'(i) * 32'h800, 0);
    hit_access("touch0", 0, 32'h0, 0, 0, 32'h0);
    miss_access("ld4000", 0, 32'h4000, 0, 0, 0, 0, 0, addr_line(32'h4000), 32'h4000, 0);
    hit_access("way0_kept", 0, 32'h4, 0, 0, 32'h4);
    hit_access("way5_kept", 0, 32'h2808, 0, 0, 32'h2808);
    miss_access("way4_gone", 0, 32'h2000, 0, 0, 0, 0, 0, addr_line(32'h2000), 32'h2000, 0);

    // reset in REFILL_WAIT abandons the miss
    do_reset();
    issue(0, 32'h1000, 0, 0);
    t = 0;
    while (!mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_rst mreq", mem_req_addr, 32'h1000);
    handshake();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = L1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray rsp_valid", rsp_valid, 1'b0);
    chk("stray req_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("stray rsp_valid2", rsp_valid, 1'b0);
    miss_access("ld1000_again", 0, 32'h1000, 0, 0, 0, 0, 0, L1, 32'h1111_1111, 0);

    // 2-way / 16-set instance: single PLRU bit alternates the victim
    sel2 = 1'b1;
    do_reset();
    miss_access("w2 ld1000", 0, 32'h1000, 0, 0, 0, 0, 0, L1, 32'h1111_1111, 0);
    hit_access("w2 ld1004", 0, 32'h1004, 0, 0, 32'h2222_2222);
    hit_access("w2 st1008", 1, 32'h1008, 32'hAABB_CCDD, 4'b0011, 32'h3333_CCDD);
    miss_access("w2 ld0", 0, 32'h0, 0, 0, 0, 0, 0, addr_line(32'h0), 32'h0, 0);
    miss_access("w2 ld100", 0, 32'h100, 0, 0, 1, 32'h1000, L1_MOD, addr_line(32'h100), 32'h100, 2);
    miss_access("w2 ld200", 0, 32'h200, 0, 0, 0, 0, 0, addr_line(32'h200), 32'h200, 0);
    hit_access("w2 hit100", 0, 32'h104, 0, 0, 32'h104);
    miss_access("w2 ld300", 0, 32'h300, 0, 0, 0, 0, 0, addr_line(32'h300), 32'h300, 0);
    hit_access("w2 hit100b", 0, 32'h100, 0, 0, 32'h100);
    miss_access("w2 ld0b", 0, 32'h0, 0, 0, 0, 0, 0, addr_line(32'h0), 32'h0, 0);
    hit_access("w2 hit100c", 0, 32'h10C, 0, 0, 32'h10C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
